// File: rtl/alu_operand_loader_if.sv
// ---------------------------------------------------------------------------
// alu_operand_loader_if
//   Bundle of the operand loader's button/data inputs and its captured ALU
//   operand outputs. Clock and reset stay outside the bundle.
//
//   master : drives load_btn, clear, in_data; observes the captured set
//   slave  : the loader itself
//
//   load_btn        raw push-button load request (asynchronous to tclk)
//   clear           synchronous abort back to the first state
//   in_data[N]      shared data for operand A, operand B and opcode
//   op_a[N]         captured operand A
//   op_b[N]         captured operand B
//   control[4]      captured ALU opcode
//   operands_valid  high while op_a/op_b/control form a complete set
//   issue           one-cycle pulse when a set completes
//   state[2]        current FSM state code (debug LEDs)
// ---------------------------------------------------------------------------
interface alu_operand_loader_if #(
    parameter int N = 4
);
    logic         load_btn;
    logic         clear;
    logic [N-1:0] in_data;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   control;
    logic         operands_valid;
    logic         issue;
    logic [1:0]   state;

    modport master (
        output load_btn,
        output clear,
        output in_data,
        input  op_a,
        input  op_b,
        input  control,
        input  operands_valid,
        input  issue,
        input  state
    );

    modport slave (
        input  load_btn,
        input  clear,
        input  in_data,
        output op_a,
        output op_b,
        output control,
        output operands_valid,
        output issue,
        output state
    );
endinterface

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//   Loads operand A, operand B and a 4-bit opcode one after another from a
//   shared data input, one value per push-button press. The button is
//   synchronized with two flops and edge-detected with a third, so holding it
//   down produces exactly one load.
//
//   tclk    : single clock, all state changes on its rising edge
//   reset   : asynchronous active-low reset, clears every flop immediately
//   bus     : alu_operand_loader_if.slave (button, clear, data in;
//             captured operands, opcode, valid, issue, state out)
//
//   State table
//     state  | code | meaning
//     S_A    | 00   | waiting for operand A
//     S_B    | 01   | waiting for operand B
//     S_OP   | 10   | waiting for opcode
//     S_DONE | 11   | complete set presented; next press starts a new set
//
//   N must be at least 4 (opcode is taken from in_data[3:0]).
// ---------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int N = 4
) (
    input logic                 tclk,
    input logic                 reset,
    alu_operand_loader_if.slave bus
);

    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_OP   = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic         btn_meta_q;
    logic         btn_sync_q;
    logic         btn_prev_q;
    logic         load_evt;

    logic [1:0]   state_q,   state_d;
    logic [N-1:0] op_a_q,    op_a_d;
    logic [N-1:0] op_b_q,    op_b_d;
    logic [3:0]   control_q, control_d;
    logic         valid_q,   valid_d;
    logic         issue_q,   issue_d;

    // Synchronizer and edge-detect flops; clear deliberately does not touch
    // them so a press held across a clear is not seen twice.
    always_ff @(posedge tclk or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= bus.load_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign load_evt = btn_sync_q & ~btn_prev_q;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        control_d = control_q;
        issue_d   = 1'b0;

        if (bus.clear) begin
            state_d   = S_A;
            op_a_d    = '0;
            op_b_d    = '0;
            control_d = '0;
        end else if (load_evt) begin
            case (state_q)
                S_A: begin
                    op_a_d  = bus.in_data;
                    state_d = S_B;
                end
                S_B: begin
                    op_b_d  = bus.in_data;
                    state_d = S_OP;
                end
                S_OP: begin
                    control_d = bus.in_data[3:0];
                    state_d   = S_DONE;
                    issue_d   = 1'b1;
                end
                S_DONE: begin
                    // New set starts; op_b/control keep the previous values
                    // until they are overwritten.
                    op_a_d  = bus.in_data;
                    state_d = S_B;
                end
                default: state_d = S_A;
            endcase
        end

        // Registered so valid tracks the state register exactly.
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge tclk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            control_q <= '0;
            valid_q   <= 1'b0;
            issue_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            control_q <= control_d;
            valid_q   <= valid_d;
            issue_q   <= issue_d;
        end
    end

    assign bus.op_a           = op_a_q;
    assign bus.op_b           = op_b_q;
    assign bus.control        = control_q;
    assign bus.operands_valid = valid_q;
    assign bus.issue          = issue_q;
    assign bus.state          = state_q;

endmodule
